pe_out_requant: RTL and testbench

Output-side requantizer for the PE array: consumes the signed 24-bit accumulator stream a PE emits and turns it back into the 8-bit activation format the PE consumes. Each accumulator is optionally ReLU'd, scaled by a per-layer 16-bit multiplier, arithmetically shifted, and saturated to u8 (ReLU mode) or s8 (raw mode). Four bytes are then packed into a 32-bit word for the activation buffer write port. All stages use valid/ready handshakes with full backpressure.

---
 rtl/pe_pkg.sv | 62 ++++++
 rtl/pe_out_requant_if.sv | 30 +++
 rtl/pe_out_packer.sv | 68 ++++++
 rtl/pe_out_requant.sv | 127 ++++++++++++
 tb/tb_pe_out_requant.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, types and helpers for the PE output requantizer.
//   ACC_W/SCALE_W/SHIFT_W : accumulator, multiplier and shift widths
//   ACT_W/BYTES_PER_WORD  : activation byte width and bytes per packed word
//   acc_t/act_t/prod_t/sum_t : datapath types
//   mode_e                : MODE_RAW (s8 clamp) / MODE_RELU (ReLU + u8 clamp)
//   sat_act()             : clamp a shifted product to the mode's byte range
//   keep_mask()           : byte-valid mask for a word ending at a given lane
package pe_pkg;

  localparam int ACC_W          = 24;
  localparam int SCALE_W        = 16;
  localparam int SHIFT_W        = 5;
  localparam int ACT_W          = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = ACT_W * BYTES_PER_WORD;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  // signed acc times zero-extended unsigned scale: one extra bit for the sign
  localparam int PROD_W         = ACC_W + SCALE_W + 1;
  // one more bit so adding the rounding constant can never overflow
  localparam int SUM_W          = PROD_W + 1;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic        [ACT_W-1:0]  act_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic        [LANE_W-1:0] lane_t;
  typedef logic [BYTES_PER_WORD-1:0] keep_t;
  typedef logic        [WORD_W-1:0] word_t;

  typedef enum logic {
    MODE_RAW  = 1'b0,
    MODE_RELU = 1'b1
  } mode_e;

  localparam sum_t SUM_ZERO = sum_t'(0);
  localparam sum_t U8_MAX   = sum_t'(255);
  localparam sum_t S8_MAX   = sum_t'(127);
  localparam sum_t S8_MIN   = sum_t'(-128);

  function automatic act_t sat_act(input sum_t r, input mode_e mode);
    act_t res;
    res = r[ACT_W-1:0];
    if (mode == MODE_RELU) begin
      if (r < SUM_ZERO)    res = 8'h00;
      else if (r > U8_MAX) res = 8'hFF;
    end else begin
      if (r < S8_MIN)      res = 8'h80;
      else if (r > S8_MAX) res = 8'h7F;
    end
    return res;
  endfunction

  function automatic keep_t keep_mask(input lane_t last_lane);
    keep_t m;
    m = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (lane_t'(k) <= last_lane) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pe_out_requant_if.sv
// pe_out_requant_if: accumulator-in / packed-word-out streaming bus.
//   in_valid/in_ready/in_acc/in_last          : accumulator stream
//   out_valid/out_ready/out_data/out_keep/out_last : packed word stream
//   master : the side that produces accumulators and consumes words
//   slave  : the requantizer
interface pe_out_requant_if;
  import pe_pkg::*;

  logic  in_valid;
  logic  in_ready;
  acc_t  in_acc;
  logic  in_last;

  logic  out_valid;
  logic  out_ready;
  word_t out_data;
  keep_t out_keep;
  logic  out_last;

  modport master (
    output in_valid, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );

  modport slave (
    input  in_valid, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );

endinterface

// File: rtl/pe_out_packer.sv
// pe_out_packer: packs a byte stream into 32-bit words.
//   clk, rst                          : clock, synchronous active-high reset
//   in_valid/in_ready/in_byte/in_last : byte stream from the requant S2 stage
//   out_valid/out_ready/out_data/out_keep/out_last : word stream
//   busy                              : a partial or complete word is held
// A word closes when lane 3 is written or when the byte carries last. The
// output word register doubles as the assembly register: a completed word
// resets the lane counter, so the next byte can only land while the word is
// being released, and it then starts a fresh word in lane 0.
module pe_out_packer
  import pe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  act_t  in_byte,
  input  logic  in_last,
  output logic  out_valid,
  input  logic  out_ready,
  output word_t out_data,
  output keep_t out_keep,
  output logic  out_last,
  output logic  busy
);

  lane_t cnt;
  logic  accept;
  logic  word_done;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign word_done = (cnt == lane_t'(BYTES_PER_WORD - 1)) || in_last;
  assign busy      = out_valid || (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (accept) begin
        // lane 0 clears the rest so short words present zeros in unused lanes
        if (cnt == '0) begin
          out_data <= word_t'(in_byte);
        end else begin
          for (int k = 1; k < BYTES_PER_WORD; k++) begin
            if (cnt == lane_t'(k)) out_data[ACT_W*k +: ACT_W] <= in_byte;
          end
        end

        if (word_done) begin
          out_valid <= 1'b1;
          out_keep  <= keep_mask(cnt);
          out_last  <= in_last;
          cnt       <= '0;
        end else begin
          cnt <= cnt + lane_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pe_out_requant.sv
// pe_out_requant: requantizes the PE accumulator stream to 8-bit activations
// and packs four of them per 32-bit word.
//   clk, rst      : clock, synchronous active-high reset
//   cfg_load      : latch cfg_scale/cfg_shift/cfg_mode (ignored while cfg_busy)
//   cfg_scale     : unsigned multiplier
//   cfg_shift     : arithmetic right shift 0..31
//   cfg_mode      : 1 = ReLU + u8 clamp, 0 = raw + s8 clamp
//   cfg_busy      : S1, S2 or the packer holds data
//   bus (slave)   : accumulator input stream and packed word output stream
// Build option: PE_REQUANT_ROUND_EN adds 2^(shift-1) before the shift
// (round half up); without it the shift truncates toward -inf.
// Pipeline: S1 = ReLU + multiply, S2 = round/shift/clamp, then the packer.
module pe_out_requant
  import pe_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [SCALE_W-1:0] cfg_scale,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_mode,
  output logic               cfg_busy,
  pe_out_requant_if.slave    bus
);

  logic [SCALE_W-1:0] scale_q;
  logic [SHIFT_W-1:0] shift_q;
  mode_e              mode_q;

  logic  s1_valid;
  prod_t s1_prod;
  logic  s1_last;
  logic  s1_advance;

  logic  s2_valid;
  act_t  s2_byte;
  logic  s2_last;
  logic  s2_advance;

  logic  pk_in_ready;
  logic  pk_busy;

  acc_t  acc_relu;
  prod_t acc_x;
  prod_t scale_x;
  sum_t  rnd;
  sum_t  sum;
  sum_t  shifted;

  assign cfg_busy = s1_valid || s2_valid || pk_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      scale_q <= SCALE_W'(1);
      shift_q <= '0;
      mode_q  <= MODE_RELU;
    end else if (cfg_load && !cfg_busy) begin
      scale_q <= cfg_scale;
      shift_q <= cfg_shift;
      mode_q  <= mode_e'(cfg_mode);
    end
  end

  // handshake chain: each stage moves when the next is empty or moving
  assign s2_advance   = s2_valid && pk_in_ready;
  assign s1_advance   = s1_valid && (!s2_valid || s2_advance);
  assign bus.in_ready = !s1_valid || s1_advance;

  // S1: ReLU then full-precision signed multiply (scale zero-extended)
  assign acc_relu = (mode_q == MODE_RELU && bus.in_acc[ACC_W-1]) ? '0 : bus.in_acc;
  assign acc_x    = prod_t'(acc_relu);
  assign scale_x  = prod_t'({1'b0, scale_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_last  <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_prod <= acc_x * scale_x;
        s1_last <= bus.in_last;
      end
    end
  end

  // S2: optional rounding constant, arithmetic shift, clamp to mode range
  always_comb begin
    rnd = '0;
`ifdef PE_REQUANT_ROUND_EN
    if (shift_q != '0) rnd = sum_t'(1) <<< (shift_q - SHIFT_W'(1));
`endif
    sum     = sum_t'(s1_prod) + rnd;
    shifted = sum >>> shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_byte  <= '0;
      s2_last  <= 1'b0;
    end else if (!s2_valid || s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_byte <= sat_act(shifted, mode_q);
        s2_last <= s1_last;
      end
    end
  end

  pe_out_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s2_valid),
    .in_ready  (pk_in_ready),
    .in_byte   (s2_byte),
    .in_last   (s2_last),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data),
    .out_keep  (bus.out_keep),
    .out_last  (bus.out_last),
    .busy      (pk_busy)
  );

endmodule

// File: tb/tb_pe_out_requant.sv
// tb_pe_out_requant: vector table plus hand sequences for pe_out_requant.
// Expected words go into a queue as stimulus is driven; a negedge monitor
// pops and compares each word the DUT hands over.
module tb_pe_out_requant;
  import pe_pkg::*;

  logic               clk;
  logic               rst;
  logic               cfg_load;
  logic [SCALE_W-1:0] cfg_scale;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               cfg_mode;
  logic               cfg_busy;

  pe_out_requant_if bus ();

  pe_out_requant dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_load  (cfg_load),
    .cfg_scale (cfg_scale),
    .cfg_shift (cfg_shift),
    .cfg_mode  (cfg_mode),
    .cfg_busy  (cfg_busy),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  typedef struct {
    logic        mode;
    logic [15:0] scale;
    logic [4:0]  shift;
    int          n;
    int          acc[4];
    logic        last;
    logic [31:0] exp_rnd;
    logic [31:0] exp_trn;
    logic [3:0]  keep;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;
  int   nwords = 0;
  int   npushed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
    q.push_back('{d: d, k: k, l: l});
    npushed++;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      nwords++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h with empty scoreboard", bus.out_data);
      end else begin
        mon_e = q.pop_front();
        chk("word_data", bus.out_data, mon_e.d);
        chk("word_keep", 32'(bus.out_keep), 32'(mon_e.k));
        chk("word_last", 32'(bus.out_last), 32'(mon_e.l));
      end
    end
  end

  // all tasks below start and end just after a posedge
  task automatic send(input int acc, input logic last, output int waits);
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_acc   = acc_t'(acc);
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 200) begin
        chk("send_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic load(input logic mode, input logic [15:0] scale, input logic [4:0] shift);
    cfg_mode  = mode;
    cfg_scale = scale;
    cfg_shift = shift;
    cfg_load  = 1'b1;
    @(posedge clk); #1;
    cfg_load  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (!cfg_busy) break;
      t++;
      if (t > 300) begin
        chk("idle_timeout", 32'(t), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int wsum;
    int n;
    int idx;
    logic acc_flag;

    vecs[0] = '{1'b1, 16'd1,      5'd2,  4, '{1002, 1001, 1000, 996}, 1'b1, 32'hF9FAFAFB, 32'hF9FAFAFA, 4'hF};
    vecs[1] = '{1'b1, 16'hFFFF,   5'd0,  2, '{32'h7FFFFF, -5, 0, 0},   1'b1, 32'h000000FF, 32'h000000FF, 4'h3};
    vecs[2] = '{1'b0, 16'd1,      5'd0,  2, '{-300, 300, 0, 0},        1'b1, 32'h00007F80, 32'h00007F80, 4'h3};
    vecs[3] = '{1'b1, 16'd1,      5'd0,  2, '{1, 2, 0, 0},             1'b1, 32'h00000201, 32'h00000201, 4'h3};
    vecs[4] = '{1'b1, 16'd1,      5'd0,  4, '{5, 6, 7, 8},             1'b0, 32'h08070605, 32'h08070605, 4'hF};
    vecs[5] = '{1'b0, 16'd3,      5'd1,  4, '{-1, -2, 40, -43},        1'b1, 32'hC03CFDFF, 32'hBF3CFDFE, 4'hF};
    vecs[6] = '{1'b0, 16'hFFFF,   5'd31, 1, '{-8388608, 0, 0, 0},      1'b1, 32'h00000080, 32'h00000080, 4'h1};

    rst = 1'b1;
    cfg_load = 1'b0;
    cfg_scale = '0;
    cfg_shift = '0;
    cfg_mode = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_acc = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_out_keep",  32'(bus.out_keep),  32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_cfg_busy",  32'(cfg_busy),      32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      wait_idle();
      load(vecs[i].mode, vecs[i].scale, vecs[i].shift);
`ifdef PE_REQUANT_ROUND_EN
      push(vecs[i].exp_rnd, vecs[i].keep, vecs[i].last);
`else
      push(vecs[i].exp_trn, vecs[i].keep, vecs[i].last);
`endif
      for (int j = 0; j < vecs[i].n; j++) begin
        send(vecs[i].acc[j], (j == vecs[i].n - 1) ? vecs[i].last : 1'b0, w);
      end
    end

    // latency from the 4th accept to out_valid
    wait_idle();
    load(1'b1, 16'd1, 5'd0);
    push(32'h14131211, 4'hF, 1'b1);
    send(32'h11, 1'b0, w);
    send(32'h12, 1'b0, w);
    send(32'h13, 1'b0, w);
    send(32'h14, 1'b1, w);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.out_valid) break;
    end
    chk("latency", 32'(n), 32'd3);
    @(posedge clk); #1;

    // sustained throughput: no wait states over 8 back-to-back inputs
    wait_idle();
    push(32'h24232221, 4'hF, 1'b0);
    push(32'h28272625, 4'hF, 1'b1);
    wsum = 0;
    for (int j = 0; j < 8; j++) begin
      send(32'h21 + j, (j == 7), w);
      wsum += w;
    end
    chk("throughput_waits", 32'(wsum), 32'd0);

    // backpressure: capacity of 6, then drain with no loss or duplication
    wait_idle();
    push(32'h04030201, 4'hF, 1'b0);
    push(32'h08070605, 4'hF, 1'b0);
    bus.out_ready = 1'b0;
    idx = 1;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = (idx <= 8);
      bus.in_acc   = acc_t'(idx);
      @(negedge clk);
      acc_flag = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc_flag) idx++;
    end
    chk("bp_accepted", 32'(idx - 1), 32'd6);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_hold_data", bus.out_data, 32'h04030201);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && idx <= 8; c++) begin
      bus.in_valid = 1'b1;
      bus.in_acc   = acc_t'(idx);
      @(negedge clk);
      acc_flag = bus.in_ready;
      @(posedge clk); #1;
      if (acc_flag) idx++;
    end
    bus.in_valid = 1'b0;
    chk("bp_all_sent", 32'(idx - 1), 32'd8);

    // config load while busy is ignored; after drain it takes effect
    wait_idle();
    load(1'b1, 16'd1, 5'd0);
    push(32'h40302010, 4'hF, 1'b1);
    send(16, 1'b0, w);
    chk("busy_before_load", 32'(cfg_busy), 32'd1);
    load(1'b1, 16'd1, 5'd4);
    send(32, 1'b0, w);
    send(48, 1'b0, w);
    send(64, 1'b1, w);
    wait_idle();
    push(32'h40302010, 4'hF, 1'b1);
    send(16, 1'b0, w);
    send(32, 1'b0, w);
    send(48, 1'b0, w);
    send(64, 1'b1, w);
    wait_idle();
    load(1'b1, 16'd1, 5'd4);
    push(32'h04030201, 4'hF, 1'b1);
    send(16, 1'b0, w);
    send(32, 1'b0, w);
    send(48, 1'b0, w);
    send(64, 1'b1, w);

    // reset mid-word discards data and restores scale=1
    wait_idle();
    load(1'b1, 16'd2, 5'd0);
    send(1, 1'b0, w);
    send(2, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy",      32'(cfg_busy),      32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    push(32'h0C0B0A09, 4'hF, 1'b1);
    send(9, 1'b0, w);
    send(10, 1'b0, w);
    send(11, 1'b0, w);
    send(12, 1'b1, w);

    wait_idle();
    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(q.size()), 32'd0);
    chk("word_count", 32'(nwords), 32'(npushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
